// File: rtl/pipe_share_pkg.sv
// Shared types and constants for the pipe_share_arbiter slice.
// Stage payloads are sized for the widest supported configuration; users take the low W / IDW bits.
package pipe_share_pkg;

  localparam int PIPE_DEPTH = 3;
  localparam int ID_MAXW    = 4;
  localparam int DATA_MAXW  = 64;

  typedef struct packed {
    logic                 valid;
    logic [ID_MAXW-1:0]   id;
    logic [DATA_MAXW-1:0] data;
    logic [DATA_MAXW-1:0] c;
  } stage_t;

  function automatic logic [1:0] count_valid(input logic v0, input logic v1, input logic v2);
    return {1'b0, v0} + {1'b0, v1} + {1'b0, v2};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the search starts at ptr, and ptr moves past the winner only on an accepted grant.
module rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx,
  output logic            any_grant
);

  logic [IDW-1:0] ptr_r;
  logic [IDW-1:0] idx_s;
  logic [IDW-1:0] win_s;
  logic           found_s;
  logic           enable_s;

  // first requester at or after ptr, wrapping modulo NREQ
  always_comb begin
    found_s = 1'b0;
    win_s   = '0;
    idx_s   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx_s = IDW'((int'(ptr_r) + k) % NREQ);
      if (!found_s && req[idx_s]) begin
        found_s = 1'b1;
        win_s   = idx_s;
      end else begin
        win_s   = win_s;
      end
    end
  end

  assign enable_s = advance && !rst && found_s;

  // one-hot grant, suppressed during stall or reset
  always_comb begin
    grant        = '0;
    grant[win_s] = enable_s;
    grant_idx    = win_s;
    any_grant    = enable_s;
  end

  // pointer advances past the winner only on an accepted grant
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r <= '0;
    end else if (enable_s) begin
      ptr_r <= (win_s == IDW'(NREQ - 1)) ? '0 : win_s + IDW'(1);
    end
  end

endmodule

// File: rtl/pipe_share_arbiter.sv
// Shares one 3-stage z = (a | b) ^ c pipeline among NREQ requesters with a global stall.
// Each result is tagged with the ID of the requester that issued it.
module pipe_share_arbiter
  import pipe_share_pkg::*;
#(
  parameter  int NREQ = 4,
  parameter  int W    = 8,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req_valid,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ*W-1:0] req_c,
  output logic [NREQ-1:0] req_ready,
  output logic            res_valid,
  output logic [W-1:0]    res_data,
  output logic [IDW-1:0]  res_id,
  input  logic            res_ready,
  output logic [1:0]      occupancy
);

  logic            advance_s;
  logic [NREQ-1:0] grant_s;
  logic [IDW-1:0]  grant_idx_s;
  logic            any_grant_s;
  logic [W-1:0]    a_sel_s;
  logic [W-1:0]    b_sel_s;
  logic [W-1:0]    c_sel_s;
  stage_t          s1_r;
  stage_t          s2_r;
  stage_t          s3_r;
  logic            unused_stage_bits_s;

  assign advance_s = !s3_r.valid || res_ready;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (req_valid),
    .advance   (advance_s),
    .grant     (grant_s),
    .grant_idx (grant_idx_s),
    .any_grant (any_grant_s)
  );

  // operand mux for the winning requester
  always_comb begin
    a_sel_s = '0;
    b_sel_s = '0;
    c_sel_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx_s == IDW'(i)) begin
        a_sel_s = req_a[i*W +: W];
        b_sel_s = req_b[i*W +: W];
        c_sel_s = req_c[i*W +: W];
      end else begin
        a_sel_s = a_sel_s;
      end
    end
  end

  // Stage registers. Payload loads only with a valid entry so the output holds its last result through bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_r <= '0;
      s2_r <= '0;
      s3_r <= '0;
    end else if (advance_s) begin
      s1_r.valid <= any_grant_s;
      if (any_grant_s) begin
        s1_r.id   <= ID_MAXW'(grant_idx_s);
        s1_r.data <= DATA_MAXW'(a_sel_s | b_sel_s);
        s1_r.c    <= DATA_MAXW'(c_sel_s);
      end
      s2_r.valid <= s1_r.valid;
      if (s1_r.valid) begin
        s2_r.id   <= s1_r.id;
        s2_r.data <= DATA_MAXW'(s1_r.data[W-1:0] ^ s1_r.c[W-1:0]);
        s2_r.c    <= '0;
      end
      s3_r.valid <= s2_r.valid;
      if (s2_r.valid) begin
        s3_r.id   <= s2_r.id;
        s3_r.data <= DATA_MAXW'(s2_r.data[W-1:0]);
        s3_r.c    <= '0;
      end
    end
  end

  assign req_ready = grant_s;
  assign res_valid = s3_r.valid;
  assign res_data  = s3_r.data[W-1:0];
  assign res_id    = s3_r.id[IDW-1:0];
  assign occupancy = count_valid(s1_r.valid, s2_r.valid, s3_r.valid);

  // payload bits above W/IDW exist only for wider configurations
  assign unused_stage_bits_s = ^{s1_r, s2_r, s3_r};

endmodule
